// File: rtl/reg_scoreboard.sv
// reg_scoreboard: RAW/WAW hazard scoreboard for the register file (ports: issue_*/src*/dst* decode in, wb_* writeback in, flush in; stall, issue_accept, pending, stall_cycles, deadlock out)
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int AW = 3,
  parameter int STALL_LIMIT = 64,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   src1_addr,
  input  logic            src1_used,
  input  logic [AW-1:0]   src2_addr,
  input  logic            src2_used,
  input  logic [AW-1:0]   dst_addr,
  input  logic            dst_wr,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
  output logic            stall,
  output logic            issue_accept,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   stall_cycles,
  output logic            deadlock
);
  localparam int RW = $clog2(STALL_LIMIT + 1);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state, state_nx;
  logic [NREG-1:0] wb_dec, set_dec, busy;
  logic [RW-1:0] run_cnt;
  logic raw, waw, hazard;
  always_comb begin
    wb_dec = '0;
    if (wb_valid) wb_dec[wb_addr] = 1'b1;
    busy = pending & ~wb_dec;
    raw = (src1_used && busy[src1_addr]) || (src2_used && busy[src2_addr]);
    waw = dst_wr && busy[dst_addr];
    hazard = issue_valid && (raw || waw);
    stall = reset ? 1'b0 : (state == FLUSH) ? 1'b1 : hazard;
    issue_accept = !reset && issue_valid && !stall && state != FLUSH && !flush;
    state_nx = flush ? FLUSH : (state == FLUSH) ? RUN : hazard ? STALL : RUN;
    set_dec = '0;
    if (issue_accept && dst_wr) set_dec[dst_addr] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pending <= '0;
      stall_cycles <= '0;
      run_cnt <= '0;
      deadlock <= 1'b0;
    end else begin
      state <= state_nx;
      pending <= flush ? '0 : busy | set_dec;
      if (stall && issue_valid && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      run_cnt <= (state != STALL) ? '0 : (run_cnt == RW'(STALL_LIMIT)) ? run_cnt : run_cnt + 1'b1;
      deadlock <= !flush && (deadlock || (state == STALL && run_cnt >= RW'(STALL_LIMIT - 1)));
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: table-driven and directed checks of reg_scoreboard
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid = 1'b0, src1_used = 1'b0, src2_used = 1'b0, dst_wr = 1'b0, wb_valid = 1'b0, flush = 1'b0;
  logic [2:0] src1_addr = '0, src2_addr = '0, dst_addr = '0, wb_addr = '0;
  logic stall, issue_accept, deadlock;
  logic [7:0] pending;
  logic [3:0] stall_cycles;
  int total = 0, bad = 0;
  typedef struct {
    logic iv; logic [2:0] s1; logic u1; logic [2:0] s2; logic u2;
    logic [2:0] d; logic dw; logic wbv; logic [2:0] wba; logic fl;
    logic e_st; logic e_acc; logic [7:0] e_pend;
  } vec_t;
  vec_t tv[17];
  vec_t h;
  always #5 clk = ~clk;
  reg_scoreboard #(.NREG(8), .AW(3), .STALL_LIMIT(4), .CW(4)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .src1_addr(src1_addr), .src1_used(src1_used),
    .src2_addr(src2_addr), .src2_used(src2_used),
    .dst_addr(dst_addr), .dst_wr(dst_wr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .stall(stall), .issue_accept(issue_accept), .pending(pending),
    .stall_cycles(stall_cycles), .deadlock(deadlock)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input string nm, input vec_t v);
    @(negedge clk);
    issue_valid = v.iv; src1_addr = v.s1; src1_used = v.u1; src2_addr = v.s2; src2_used = v.u2;
    dst_addr = v.d; dst_wr = v.dw; wb_valid = v.wbv; wb_addr = v.wba; flush = v.fl;
    #1;
    chk({nm, " stall"}, 32'(stall), 32'(v.e_st));
    chk({nm, " accept"}, 32'(issue_accept), 32'(v.e_acc));
    @(posedge clk);
    #1;
    chk({nm, " pending"}, 32'(pending), 32'(v.e_pend));
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    issue_valid = 1'b0; src1_used = 1'b0; src2_used = 1'b0; dst_wr = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    #1;
    chk("rst pending", 32'(pending), 32'h0);
    chk("rst stall_cycles", 32'(stall_cycles), 32'h0);
    chk("rst deadlock", 32'(deadlock), 32'h0);
    chk("rst stall", 32'(stall), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    tv[0]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd3,1'b1,1'b0,3'd0,1'b0, 1'b0,1'b1,8'h08};
    tv[1]  = '{1'b1,3'd3,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h08};
    tv[2]  = '{1'b1,3'd3,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h08};
    tv[3]  = '{1'b1,3'd3,1'b1,3'd0,1'b0,3'd0,1'b0,1'b1,3'd3,1'b0, 1'b0,1'b1,8'h00};
    tv[4]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd5,1'b1,1'b0,3'd0,1'b0, 1'b0,1'b1,8'h20};
    tv[5]  = '{1'b1,3'd1,1'b1,3'd5,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0, 1'b0,1'b1,8'h20};
    tv[6]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd2,1'b1,1'b0,3'd0,1'b0, 1'b0,1'b1,8'h24};
    tv[7]  = '{1'b1,3'd0,1'b1,3'd0,1'b0,3'd2,1'b1,1'b1,3'd2,1'b0, 1'b0,1'b1,8'h24};
    tv[8]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd6,1'b1,1'b1,3'd5,1'b0, 1'b0,1'b1,8'h44};
    tv[9]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h44};
    tv[10] = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h44};
    tv[11] = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd6,1'b1,1'b1,3'd6,1'b0, 1'b0,1'b1,8'h44};
    tv[12] = '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b1,3'd2,1'b0, 1'b0,1'b0,8'h40};
    tv[13] = '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b1,3'd1,1'b0, 1'b0,1'b0,8'h40};
    tv[14] = '{1'b1,3'd6,1'b1,3'd6,1'b1,3'd6,1'b1,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h40};
    tv[15] = '{1'b1,3'd6,1'b1,3'd6,1'b1,3'd6,1'b1,1'b1,3'd6,1'b0, 1'b0,1'b1,8'h40};
    tv[16] = '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b1,3'd6,1'b0, 1'b0,1'b0,8'h00};
    #1;
    chk("rst accept", 32'(issue_accept), 32'h0);
    do_reset();
    for (int i = 0; i < 17; i++) cyc($sformatf("vec%0d", i), tv[i]);
    chk("table stall_cycles", 32'(stall_cycles), 32'd5);
    chk("table deadlock", 32'(deadlock), 32'h0);
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc("fl fill", '{1'b1,3'd0,1'b0,3'd0,1'b0,3'(i),1'b1,1'b0,3'd0,1'b0, 1'b0,1'b1,8'((2 << i) - 1)});
    h = '{1'b1,3'd1,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h0F};
    cyc("fl stall1", h);
    cyc("fl stall2", h);
    h.fl = 1'b1; h.e_pend = 8'h00;
    cyc("fl flush", h);
    h.fl = 1'b0;
    cyc("fl flushstate", h);
    h.e_st = 1'b0; h.e_acc = 1'b1;
    cyc("fl resume", h);
    chk("fl stall_cycles", 32'(stall_cycles), 32'd4);
    do_reset();
    cyc("wd fill", '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd7,1'b1,1'b0,3'd0,1'b0, 1'b0,1'b1,8'h80});
    h = '{1'b1,3'd7,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h80};
    for (int k = 1; k <= 6; k++) begin
      cyc($sformatf("wd hold%0d", k), h);
      chk($sformatf("wd deadlock%0d", k), 32'(deadlock), 32'(k >= 5));
    end
    chk("wd stall_cycles6", 32'(stall_cycles), 32'd6);
    for (int k = 0; k < 10; k++) cyc("wd more", h);
    chk("wd stall_cycles sat", 32'(stall_cycles), 32'd15);
    chk("wd deadlock held", 32'(deadlock), 32'h1);
    h.fl = 1'b1; h.e_pend = 8'h00;
    cyc("wd flush", h);
    chk("wd deadlock cleared", 32'(deadlock), 32'h0);
    cyc("ar idle", '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0, 1'b1,1'b0,8'h00});
    cyc("ar fill", '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd4,1'b1,1'b0,3'd0,1'b0, 1'b0,1'b1,8'h10});
    @(negedge clk);
    issue_valid = 1'b1; src1_addr = 3'd4; src1_used = 1'b1; dst_wr = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    #1 chk("ar stall before", 32'(stall), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("ar pending", 32'(pending), 32'h0);
    chk("ar stall", 32'(stall), 32'h0);
    chk("ar accept", 32'(issue_accept), 32'h0);
    chk("ar stall_cycles", 32'(stall_cycles), 32'h0);
    reset = 1'b0;
    #1 chk("ar accept after", 32'(issue_accept), 32'h1);
    @(posedge clk);
    #1 chk("ar pending after", 32'(pending), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 8-entry, 16-bit register file and stalls decode on RAW and WAW hazards.
- Sits between decode and the register file read stage; writeback clears entries.
- Provides a flush path, a stall-cycle performance counter and a sticky deadlock watchdog.

Parameters:
- NREG, 8, number of architectural registers; must be a power of 2.
- AW, 3, register address width, equal to log2(NREG).
- STALL_LIMIT, 64, consecutive stall cycles after which `deadlock` sets.
- CW, 16, width of the stall performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  decode presents an instruction this cycle.
- `src1_addr`  in  AW  first source register.
- `src1_used`  in  1  instruction reads `src1_addr`.
- `src2_addr`  in  AW  second source register.
- `src2_used`  in  1  instruction reads `src2_addr`; low for one-operand ops.
- `dst_addr`  in  AW  destination register.
- `dst_wr`  in  1  instruction writes `dst_addr`.
- `wb_valid`  in  1  writeback writes the register file this cycle.
- `wb_addr`  in  AW  writeback destination.
- `flush`  in  1  discard all in-flight producers (branch or reset-like event).
- `stall`  out  1  hold decode/fetch this cycle (combinational).
- `issue_accept`  out  1  instruction accepted this cycle (combinational).
- `pending`  out  NREG  registered busy bit per register.
- `stall_cycles`  out  CW  saturating count of stalled issue cycles.
- `deadlock`  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, immediate):
  - `pending`=0, FSM=RUN, `stall_cycles`=0, `deadlock`=0, internal stall-run counter=0.
  - `stall` and `issue_accept` are 0 while reset is high.
- Same-cycle writeback resolves a hazard. The register file writes on posedge and reads on negedge, so `wb_valid` && `wb_addr`==X makes X not busy for hazard checks in that same cycle.
- Busy-check definitions:
  - busy(X) = `pending`[X] && !(`wb_valid` && `wb_addr`==X).
  - raw = (`src1_used` && busy(`src1_addr`)) || (`src2_used` && busy(`src2_addr`)).
  - waw = `dst_wr` && busy(`dst_addr`).
  - hazard = `issue_valid` && (raw || waw).
- FSM states: RUN, STALL, FLUSH.
  - RUN: `stall`=hazard. hazard -> STALL; `flush` -> FLUSH; else stay in RUN.
  - STALL: `stall`=hazard. !hazard -> RUN, and the instruction issues that same cycle. `flush` -> FLUSH.
  - FLUSH: one cycle; `stall`=1, `issue_accept`=0; -> RUN unconditionally, or stay in FLUSH if `flush` is still high.
  - `flush` has priority over every other transition.
- Issue: `issue_accept` = `issue_valid` && !`stall` && state!=FLUSH && !`flush`.
- Pending update at posedge, in priority order:
  1. `flush`: `pending`<=0; writeback and issue are ignored.
  2. `wb_valid`: clear `pending`[`wb_addr`].
  3. `issue_accept` && `dst_wr`: set `pending`[`dst_addr`]. Set wins over a same-address clear in the same cycle.
- Writeback to a non-pending register is legal and has no effect.
- `src1`==`src2`, or src==dst, needs no special casing.
- `stall_cycles` increments when `stall` && `issue_valid`, saturating at 2^CW-1. It is cleared only by `reset`.
- Watchdog:
  - A run counter increments each cycle state==STALL and resets to 0 whenever state!=STALL.
  - Reaching STALL_LIMIT sets `deadlock`, which holds until `reset` or `flush`.
  - `deadlock` does not alter stall behaviour.
- Latency: the hazard decision is same-cycle (combinational). Pending visibility is next cycle.

Test Plan:
- Back-to-back RAW: issue dst=R3, next cycle src1=R3 with no wb -> `stall`=1, state STALL. wb_addr=3 two cycles later -> `stall`=0, `issue_accept`=1 in the wb cycle, `pending`[3]=0.
- One-operand op: src2_used=0 with src2=R5 while `pending`[5]=1 -> no stall, `issue_accept`=1.
- Simultaneous wb R2 and issue dst=R2 (src unrelated) -> accept; `pending`[2]=1 next cycle.
- WAW: `pending`[6]=1, issue dst=R6, no sources -> stall until wb R6, then accept and `pending`[6]=1.
- Flush mid-stall: `pending`=8'h0F, stalled on R1, assert `flush` for 1 cycle -> `pending`=0, one FLUSH cycle with `stall`=1 and `issue_accept`=0, then RUN and accept.
- Watchdog and counter: STALL_LIMIT=4, hold a hazard for 6 cycles -> `deadlock`=1 after the 4th STALL cycle, `stall_cycles`=6. Asserting `flush` then clears `deadlock`.
- Async reset mid-stall: reset pulse between edges -> `pending`=0 and `stall`=0 immediately.
